// File: rtl/time_set_ctrl.sv
//------------------------------------------------------------------------------
// time_set_ctrl
//
// Purpose:
//   Key-driven editor for a HH:MM:SS time counter. A mode key freezes the
//   counter, copies the live time into an edit buffer and steps through the
//   hour, minute and second fields. Inc/dec keys change the selected field
//   with wrap-around. A final mode key commits the buffer with a one-cycle
//   load pulse. A no-key timeout abandons the edit without loading. A blink
//   phase output lets the display flash the field being edited.
//
// Build option:
//   TIME_SET_DEC_EN  - when defined, key_dec decrements the selected field.
//                      When undefined, key_dec is accepted but has no effect.
//
// Ports:
//   clk                     in   system clock
//   rst                     in   synchronous reset, active low
//   key_mode                in   single-cycle pulse: enter edit / next field / commit
//   key_inc                 in   single-cycle pulse: increment selected field
//   key_dec                 in   single-cycle pulse: decrement selected field
//   cur_hour/minute/second  in   live time from the time counter (6 bits each)
//   set_hour/minute/second  out  edit buffer (6 bits each)
//   load                    out  one-cycle commit pulse for set_*
//   run_en                  out  time counter count enable
//   field_sel               out  0 none, 1 hour, 2 minute, 3 second
//   blink_on                out  visible phase of the selected field
//
// All outputs are registered.
//------------------------------------------------------------------------------
module time_set_ctrl #(
   parameter logic [5:0]  HOUR_MAX   = 6'd23,
   parameter logic [5:0]  MINUTE_MAX = 6'd59,
   parameter logic [5:0]  SECOND_MAX = 6'd59,
   parameter logic [25:0] BLINK_MAX  = 26'd24_999_999,
   parameter logic [29:0] IDLE_MAX   = 30'd499_999_999
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic       key_dec,
   input  logic [5:0] cur_hour,
   input  logic [5:0] cur_minute,
   input  logic [5:0] cur_second,
   output logic [5:0] set_hour,
   output logic [5:0] set_minute,
   output logic [5:0] set_second,
   output logic       load,
   output logic       run_en,
   output logic [1:0] field_sel,
   output logic       blink_on
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SET_H = 3'd1,
      ST_SET_M = 3'd2,
      ST_SET_S = 3'd3,
      ST_APPLY = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      DIR_HOLD = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_t;

   // Increment with wrap to zero; anything at or above max also wraps so
   // the field can never leave its legal range.
   function automatic logic [5:0] wrap_inc(input logic [5:0] val,
                                           input logic [5:0] max);
      logic [5:0] res;
      if (val >= max) begin
         res = 6'd0;
      end else begin
         res = val + 6'd1;
      end
      return res;
   endfunction

   // Decrement with wrap from zero to max; out-of-range values snap to max.
   function automatic logic [5:0] wrap_dec(input logic [5:0] val,
                                           input logic [5:0] max);
      logic [5:0] res;
      if ((val == 6'd0) || (val > max)) begin
         res = max;
      end else begin
         res = val - 6'd1;
      end
      return res;
   endfunction

   // Apply one edit step in the requested direction.
   function automatic logic [5:0] edit_field(input logic [5:0] val,
                                             input logic [5:0] max,
                                             input dir_t      dir);
      logic [5:0] res;
      case (dir)
         DIR_UP:   res = wrap_inc(val, max);
         DIR_DN:   res = wrap_dec(val, max);
         DIR_HOLD: res = val;
         default:  res = val;
      endcase
      return res;
   endfunction

   state_t      state_q,      state_d;
   logic [5:0]  set_hour_q,   set_hour_d;
   logic [5:0]  set_minute_q, set_minute_d;
   logic [5:0]  set_second_q, set_second_d;
   logic        load_q,       load_d;
   logic        run_en_q,     run_en_d;
   logic [1:0]  field_sel_q,  field_sel_d;
   logic        blink_on_q,   blink_on_d;
   logic [25:0] blink_cnt_q,  blink_cnt_d;
   logic [29:0] idle_cnt_q,   idle_cnt_d;

   logic        key_dec_s;
   logic        key_any_s;
   logic        in_edit_d_s;
   dir_t        dir_s;

   // Without the decrement option key_dec is masked off here, so every
   // downstream use sees a constant zero and inc acts alone.
`ifdef TIME_SET_DEC_EN
   assign key_dec_s = key_dec;
`else
   assign key_dec_s = key_dec & 1'b0;
`endif

   assign key_any_s = key_mode | key_inc | key_dec_s;

   // Resolve the edit direction; simultaneous inc and dec cancel out.
   always_comb begin
      dir_s = DIR_HOLD;
      if (key_inc && !key_dec_s) begin
         dir_s = DIR_UP;
      end else if (key_dec_s && !key_inc) begin
         dir_s = DIR_DN;
      end else begin
         dir_s = DIR_HOLD;
      end
   end

   // Next-state, edit buffer, output and counter computation.
   always_comb begin
      state_d      = state_q;
      set_hour_d   = set_hour_q;
      set_minute_d = set_minute_q;
      set_second_d = set_second_q;
      load_d       = 1'b0;
      run_en_d     = run_en_q;
      field_sel_d  = field_sel_q;
      blink_on_d   = blink_on_q;
      blink_cnt_d  = blink_cnt_q;
      idle_cnt_d   = idle_cnt_q;
      in_edit_d_s  = 1'b0;

      // ---- state transitions and field edits ----
      case (state_q)
         ST_IDLE: begin
            if (key_mode) begin
               // Snapshot the live time on the same edge that leaves IDLE.
               set_hour_d   = cur_hour;
               set_minute_d = cur_minute;
               set_second_d = cur_second;
               state_d      = ST_SET_H;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SET_H: begin
            if (key_mode) begin
               state_d = ST_SET_M;
            end else if (!key_any_s && (idle_cnt_q == IDLE_MAX)) begin
               state_d = ST_IDLE;
            end else begin
               set_hour_d = edit_field(set_hour_q, HOUR_MAX, dir_s);
            end
         end
         ST_SET_M: begin
            if (key_mode) begin
               state_d = ST_SET_S;
            end else if (!key_any_s && (idle_cnt_q == IDLE_MAX)) begin
               state_d = ST_IDLE;
            end else begin
               set_minute_d = edit_field(set_minute_q, MINUTE_MAX, dir_s);
            end
         end
         ST_SET_S: begin
            if (key_mode) begin
               state_d = ST_APPLY;
            end else if (!key_any_s && (idle_cnt_q == IDLE_MAX)) begin
               state_d = ST_IDLE;
            end else begin
               set_second_d = edit_field(set_second_q, SECOND_MAX, dir_s);
            end
         end
         ST_APPLY: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // ---- registered outputs follow the state being entered ----
      case (state_d)
         ST_IDLE: begin
            run_en_d    = 1'b1;
            field_sel_d = 2'd0;
            load_d      = 1'b0;
         end
         ST_SET_H: begin
            run_en_d    = 1'b0;
            field_sel_d = 2'd1;
            load_d      = 1'b0;
            in_edit_d_s = 1'b1;
         end
         ST_SET_M: begin
            run_en_d    = 1'b0;
            field_sel_d = 2'd2;
            load_d      = 1'b0;
            in_edit_d_s = 1'b1;
         end
         ST_SET_S: begin
            run_en_d    = 1'b0;
            field_sel_d = 2'd3;
            load_d      = 1'b0;
            in_edit_d_s = 1'b1;
         end
         ST_APPLY: begin
            run_en_d    = 1'b0;
            field_sel_d = 2'd0;
            load_d      = 1'b1;
         end
         default: begin
            run_en_d    = 1'b1;
            field_sel_d = 2'd0;
            load_d      = 1'b0;
         end
      endcase

      // ---- blink and inactivity counters ----
      // Any key or field change restarts both so the freshly touched field
      // is shown solid and the timeout measures time since the last key.
      if (!in_edit_d_s) begin
         blink_cnt_d = 26'd0;
         idle_cnt_d  = 30'd0;
         blink_on_d  = 1'b1;
      end else if (key_any_s || (state_d != state_q)) begin
         blink_cnt_d = 26'd0;
         idle_cnt_d  = 30'd0;
         blink_on_d  = 1'b1;
      end else begin
         if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = 26'd0;
            blink_on_d  = ~blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 26'd1;
            blink_on_d  = blink_on_q;
         end
         // Cannot pass IDLE_MAX: reaching it forces the exit above.
         idle_cnt_d = idle_cnt_q + 30'd1;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         set_hour_q   <= 6'd0;
         set_minute_q <= 6'd0;
         set_second_q <= 6'd0;
         load_q       <= 1'b0;
         run_en_q     <= 1'b1;
         field_sel_q  <= 2'd0;
         blink_on_q   <= 1'b1;
         blink_cnt_q  <= 26'd0;
         idle_cnt_q   <= 30'd0;
      end else begin
         state_q      <= state_d;
         set_hour_q   <= set_hour_d;
         set_minute_q <= set_minute_d;
         set_second_q <= set_second_d;
         load_q       <= load_d;
         run_en_q     <= run_en_d;
         field_sel_q  <= field_sel_d;
         blink_on_q   <= blink_on_d;
         blink_cnt_q  <= blink_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
      end
   end

   assign set_hour   = set_hour_q;
   assign set_minute = set_minute_q;
   assign set_second = set_second_q;
   assign load       = load_q;
   assign run_en     = run_en_q;
   assign field_sel  = field_sel_q;
   assign blink_on   = blink_on_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
//------------------------------------------------------------------------------
// tb_time_set_ctrl
//
// Directed bench for time_set_ctrl with BLINK_MAX=3 and IDLE_MAX=20.
// Each step drives one cycle of key pulses, pushes the expected output
// snapshot for the following edge into a scoreboard queue, then pops and
// compares it shortly after that edge.
// Expectations for key_dec depend on TIME_SET_DEC_EN.
//------------------------------------------------------------------------------
module tb_time_set_ctrl;

   logic       clk;
   logic       rst;
   logic       key_mode;
   logic       key_inc;
   logic       key_dec;
   logic [5:0] cur_hour;
   logic [5:0] cur_minute;
   logic [5:0] cur_second;
   logic [5:0] set_hour;
   logic [5:0] set_minute;
   logic [5:0] set_second;
   logic       load;
   logic       run_en;
   logic [1:0] field_sel;
   logic       blink_on;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      string      tag;
      logic [5:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic       ld;
      logic       run;
      logic [1:0] fs;
      logic       bl;
   } exp_t;

   exp_t sbq[$];

   time_set_ctrl #(
      .HOUR_MAX   (6'd23),
      .MINUTE_MAX (6'd59),
      .SECOND_MAX (6'd59),
      .BLINK_MAX  (26'd3),
      .IDLE_MAX   (30'd20)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_mode   (key_mode),
      .key_inc    (key_inc),
      .key_dec    (key_dec),
      .cur_hour   (cur_hour),
      .cur_minute (cur_minute),
      .cur_second (cur_second),
      .set_hour   (set_hour),
      .set_minute (set_minute),
      .set_second (set_second),
      .load       (load),
      .run_en     (run_en),
      .field_sel  (field_sel),
      .blink_on   (blink_on)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the run never reaches its summary.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pop_and_check();
      exp_t e;
      if (sbq.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sbq.pop_front();
         chk({e.tag, ".hour"},      {26'd0, set_hour},   {26'd0, e.h});
         chk({e.tag, ".minute"},    {26'd0, set_minute}, {26'd0, e.m});
         chk({e.tag, ".second"},    {26'd0, set_second}, {26'd0, e.s});
         chk({e.tag, ".load"},      {31'd0, load},       {31'd0, e.ld});
         chk({e.tag, ".run_en"},    {31'd0, run_en},     {31'd0, e.run});
         chk({e.tag, ".field_sel"}, {30'd0, field_sel},  {30'd0, e.fs});
         chk({e.tag, ".blink_on"},  {31'd0, blink_on},   {31'd0, e.bl});
      end
   endtask

   // One clock: drive keys, queue the expected post-edge outputs, check them.
   task automatic step(input string tag, input logic km, input logic ki, input logic kd,
                       input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                       input logic ld, input logic run, input logic [1:0] fs, input logic bl);
      exp_t e;
      @(negedge clk);
      key_mode = km;
      key_inc  = ki;
      key_dec  = kd;
      e.tag = tag; e.h = h; e.m = m; e.s = s;
      e.ld = ld; e.run = run; e.fs = fs; e.bl = bl;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      key_mode = 1'b0;
      key_inc  = 1'b0;
      key_dec  = 1'b0;
      pop_and_check();
   endtask

   logic [5:0] hexp;
   logic [5:0] mexp;
   logic [5:0] sexp;

   initial begin
      rst        = 1'b0;
      key_mode   = 1'b0;
      key_inc    = 1'b0;
      key_dec    = 1'b0;
      cur_hour   = 6'd12;
      cur_minute = 6'd34;
      cur_second = 6'd56;

      // Reset values, and live time is not captured while in reset.
      step("reset", 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 2'd0, 1'b1);
      rst = 1'b1;
      step("idle_hold", 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 2'd0, 1'b1);
      step("idle_inc_ignored", 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 2'd0, 1'b1);
      step("idle_dec_ignored", 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 2'd0, 1'b1);

      // Enter edit: capture 12:34:56, hour selected, counter stopped.
      step("enter_set_h", 1'b1, 1'b0, 1'b0, 6'd12, 6'd34, 6'd56, 1'b0, 1'b0, 2'd1, 1'b1);

      // Hour up to 23, wrap to 0, then on to 5.
      hexp = 6'd12;
      while (hexp != 6'd23) begin
         hexp = hexp + 6'd1;
         step("hour_inc", 1'b0, 1'b1, 1'b0, hexp, 6'd34, 6'd56, 1'b0, 1'b0, 2'd1, 1'b1);
      end
      hexp = 6'd0;
      step("hour_wrap", 1'b0, 1'b1, 1'b0, hexp, 6'd34, 6'd56, 1'b0, 1'b0, 2'd1, 1'b1);
      while (hexp != 6'd5) begin
         hexp = hexp + 6'd1;
         step("hour_inc2", 1'b0, 1'b1, 1'b0, hexp, 6'd34, 6'd56, 1'b0, 1'b0, 2'd1, 1'b1);
      end

      // Mode together with inc: field advances, hour untouched.
      step("mode_wins_h", 1'b1, 1'b1, 1'b0, 6'd5, 6'd34, 6'd56, 1'b0, 1'b0, 2'd2, 1'b1);

      // Minute up to 59 and wrap to 0.
      mexp = 6'd34;
      while (mexp != 6'd59) begin
         mexp = mexp + 6'd1;
         step("minute_inc", 1'b0, 1'b1, 1'b0, 6'd5, mexp, 6'd56, 1'b0, 1'b0, 2'd2, 1'b1);
      end
      mexp = 6'd0;
      step("minute_wrap", 1'b0, 1'b1, 1'b0, 6'd5, mexp, 6'd56, 1'b0, 1'b0, 2'd2, 1'b1);

`ifdef TIME_SET_DEC_EN
      mexp = 6'd59;
      step("minute_dec_wrap", 1'b0, 1'b0, 1'b1, 6'd5, mexp, 6'd56, 1'b0, 1'b0, 2'd2, 1'b1);
      step("minute_inc_dec", 1'b0, 1'b1, 1'b1, 6'd5, mexp, 6'd56, 1'b0, 1'b0, 2'd2, 1'b1);
`else
      mexp = 6'd0;
      step("minute_dec_ignored", 1'b0, 1'b0, 1'b1, 6'd5, mexp, 6'd56, 1'b0, 1'b0, 2'd2, 1'b1);
      mexp = 6'd1;
      step("minute_inc_dec", 1'b0, 1'b1, 1'b1, 6'd5, mexp, 6'd56, 1'b0, 1'b0, 2'd2, 1'b1);
`endif
      while (mexp != 6'd7) begin
         mexp = (mexp == 6'd59) ? 6'd0 : mexp + 6'd1;
         step("minute_inc2", 1'b0, 1'b1, 1'b0, 6'd5, mexp, 6'd56, 1'b0, 1'b0, 2'd2, 1'b1);
      end

      // Mode together with inc in SET_M: minute untouched.
      step("mode_wins_m", 1'b1, 1'b1, 1'b0, 6'd5, 6'd7, 6'd56, 1'b0, 1'b0, 2'd3, 1'b1);

      // Second from 56 through wrap to 9.
      sexp = 6'd56;
      while (sexp != 6'd9) begin
         sexp = (sexp == 6'd59) ? 6'd0 : sexp + 6'd1;
         step("second_inc", 1'b0, 1'b1, 1'b0, 6'd5, 6'd7, sexp, 1'b0, 1'b0, 2'd3, 1'b1);
      end

      // Commit: one cycle of load, then back to running.
      step("apply", 1'b1, 1'b0, 1'b0, 6'd5, 6'd7, 6'd9, 1'b1, 1'b0, 2'd0, 1'b1);
      step("after_apply", 1'b0, 1'b0, 1'b0, 6'd5, 6'd7, 6'd9, 1'b0, 1'b1, 2'd0, 1'b1);
      step("after_apply2", 1'b0, 1'b0, 1'b0, 6'd5, 6'd7, 6'd9, 1'b0, 1'b1, 2'd0, 1'b1);

      // Timeout abort from SET_S, with blink toggling every 4 cycles.
      cur_hour   = 6'd10;
      cur_minute = 6'd20;
      cur_second = 6'd30;
      step("abort_set_h", 1'b1, 1'b0, 1'b0, 6'd10, 6'd20, 6'd30, 1'b0, 1'b0, 2'd1, 1'b1);
      step("abort_set_m", 1'b1, 1'b0, 1'b0, 6'd10, 6'd20, 6'd30, 1'b0, 1'b0, 2'd2, 1'b1);
      step("abort_set_s", 1'b1, 1'b0, 1'b0, 6'd10, 6'd20, 6'd30, 1'b0, 1'b0, 2'd3, 1'b1);
      for (int j = 1; j <= 20; j++) begin
         step("abort_wait", 1'b0, 1'b0, 1'b0, 6'd10, 6'd20, 6'd30, 1'b0, 1'b0, 2'd3,
              (((j / 4) % 2) == 0) ? 1'b1 : 1'b0);
      end
      step("abort_idle", 1'b0, 1'b0, 1'b0, 6'd10, 6'd20, 6'd30, 1'b0, 1'b1, 2'd0, 1'b1);
      step("abort_no_load", 1'b0, 1'b0, 1'b0, 6'd10, 6'd20, 6'd30, 1'b0, 1'b1, 2'd0, 1'b1);

      // Reset in the middle of an edit discards it.
      step("rst_edit_h", 1'b1, 1'b0, 1'b0, 6'd10, 6'd20, 6'd30, 1'b0, 1'b0, 2'd1, 1'b1);
      step("rst_edit_m", 1'b1, 1'b0, 1'b0, 6'd10, 6'd20, 6'd30, 1'b0, 1'b0, 2'd2, 1'b1);
      step("rst_edit_inc", 1'b0, 1'b1, 1'b0, 6'd10, 6'd21, 6'd30, 1'b0, 1'b0, 2'd2, 1'b1);
      rst = 1'b0;
      step("rst_mid_edit", 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 2'd0, 1'b1);
      rst = 1'b1;
      step("post_rst", 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 2'd0, 1'b1);
      step("post_rst2", 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 2'd0, 1'b1);

      chk("sb_empty", sbq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
